// File: rtl/prog_loader.sv
// UART (8N1) program loader: assembles little-endian 32-bit words from RXD,
// writes them to IMEM and releases the core reset once LOAD_WORDS are loaded.
module prog_loader #(
  parameter int unsigned SERIAL_WCNT = 20,
  parameter int unsigned LOAD_WORDS  = 64,
  parameter int unsigned ADDR_W      = 9
) (
  input  logic              CLK,
  input  logic              RST_X,
  input  logic              RXD,
  output logic              O_WE,
  output logic [ADDR_W-1:0] O_ADDR,
  output logic [31:0]       O_DATA,
  output logic              O_CORE_RST_X,
  output logic              O_DONE,
  output logic              O_FERR
);

  localparam int unsigned CNT_W  = (SERIAL_WCNT > 2) ? $clog2(SERIAL_WCNT) : 1;
  localparam int unsigned HALF   = SERIAL_WCNT / 2;
  localparam int unsigned WCNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  rx_state_e          state;
  rx_state_e          state_nxt;
  logic               rxd_s1;
  logic               rxd_s2;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         bit_cnt;
  logic [7:0]         shift;
  logic [1:0]         byte_cnt;
  logic [23:0]        word_buf;
  logic [WCNT_W-1:0]  word_cnt;

  logic tick_half_c;
  logic tick_full_c;
  logic full_c;
  logic cnt_clr_c;
  logic bit_shift_c;
  logic byte_ok_c;
  logic ferr_set_c;

  assign tick_half_c = (cnt == CNT_W'(HALF - 1));
  assign tick_full_c = (cnt == CNT_W'(SERIAL_WCNT - 1));
  assign full_c      = (word_cnt >= WCNT_W'(LOAD_WORDS));

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
    end else begin
      rxd_s1 <= RXD;
      rxd_s2 <= rxd_s1;
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!rxd_s2) state_nxt = START;
      START: if (tick_half_c) state_nxt = rxd_s2 ? IDLE : DATA;
      DATA:  if (tick_full_c && (bit_cnt == 3'd7)) state_nxt = STOP;
      STOP:  if (tick_full_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state sampling strobes driving the datapath below
  always_comb begin
    cnt_clr_c   = 1'b0;
    bit_shift_c = 1'b0;
    byte_ok_c   = 1'b0;
    ferr_set_c  = 1'b0;
    case (state)
      IDLE:  cnt_clr_c = 1'b1;
      START: cnt_clr_c = tick_half_c;
      DATA: begin
        cnt_clr_c   = tick_full_c;
        bit_shift_c = tick_full_c;
      end
      STOP: begin
        cnt_clr_c  = tick_full_c;
        byte_ok_c  = tick_full_c & rxd_s2;
        ferr_set_c = tick_full_c & ~rxd_s2;
      end
      default: cnt_clr_c = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      cnt <= cnt_clr_c ? '0 : cnt + CNT_W'(1);
      if (bit_shift_c) begin
        shift   <= {rxd_s2, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // Word assembly and IMEM write; bytes after the load completes are dropped
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      byte_cnt <= '0;
      word_buf <= '0;
      word_cnt <= '0;
      O_WE     <= 1'b0;
      O_ADDR   <= '0;
      O_DATA   <= '0;
    end else begin
      O_WE <= 1'b0;
      if (byte_ok_c && !full_c) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0: word_buf[7:0]   <= shift;
          2'd1: word_buf[15:8]  <= shift;
          2'd2: word_buf[23:16] <= shift;
          default: begin
            O_WE     <= 1'b1;
            O_ADDR   <= word_cnt[ADDR_W-1:0];
            O_DATA   <= {shift, word_buf};
            word_cnt <= word_cnt + WCNT_W'(1);
          end
        endcase
      end
    end
  end

  // Status flags; done and core reset release share one condition
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      O_DONE       <= 1'b0;
      O_CORE_RST_X <= 1'b0;
      O_FERR       <= 1'b0;
    end else begin
      if (full_c) begin
        O_DONE       <= 1'b1;
        O_CORE_RST_X <= 1'b1;
      end
      if (ferr_set_c) O_FERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed load scenarios on one instance and randomized
// back-to-back traffic on a fast instance, checked against a byte-level model.
module tb_prog_loader;

  localparam int unsigned WA  = 8;
  localparam int unsigned LA  = 2;
  localparam int unsigned AWA = 9;
  localparam int unsigned WB  = 4;
  localparam int unsigned LB  = 8;
  localparam int unsigned AWB = 3;

  logic           CLK = 1'b0;
  logic           rst_a_x, rxd_a, we_a, crst_a, done_a, ferr_a;
  logic [AWA-1:0] addr_a;
  logic [31:0]    data_a;
  logic           rst_b_x, rxd_b, we_b, crst_b, done_b, ferr_b;
  logic [AWB-1:0] addr_b;
  logic [31:0]    data_b;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_we_a = -10;
  int last_we_b = -10;
  logic pd_a = 1'b0;
  logic pd_b = 1'b0;

  logic [31:0] pw[2];
  int          pn[2];
  int          widx[2];
  bit          mdone[2];
  bit          mferr_b;
  logic [63:0] expq_a[$];
  logic [63:0] expq_b[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  prog_loader #(.SERIAL_WCNT(WA), .LOAD_WORDS(LA), .ADDR_W(AWA)) dut_a (
    .CLK(CLK), .RST_X(rst_a_x), .RXD(rxd_a), .O_WE(we_a), .O_ADDR(addr_a),
    .O_DATA(data_a), .O_CORE_RST_X(crst_a), .O_DONE(done_a), .O_FERR(ferr_a)
  );

  prog_loader #(.SERIAL_WCNT(WB), .LOAD_WORDS(LB), .ADDR_W(AWB)) dut_b (
    .CLK(CLK), .RST_X(rst_b_x), .RXD(rxd_b), .O_WE(we_b), .O_ADDR(addr_b),
    .O_DATA(data_b), .O_CORE_RST_X(crst_b), .O_DONE(done_b), .O_FERR(ferr_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: what an 8N1 receiver feeding a word packer must write
  task automatic model_reset(input int sel);
    pw[sel]    = '0;
    pn[sel]    = 0;
    widx[sel]  = 0;
    mdone[sel] = 1'b0;
  endtask

  task automatic model_byte(input int sel, input logic [7:0] b, input bit ok);
    logic [63:0] e;
    if (!ok || mdone[sel]) return;
    pw[sel][8*pn[sel] +: 8] = b;
    pn[sel]++;
    if (pn[sel] == 4) begin
      e = {32'(widx[sel]), pw[sel]};
      if (sel == 0) expq_a.push_back(e);
      else          expq_b.push_back(e);
      widx[sel]++;
      pn[sel] = 0;
      if (widx[sel] == ((sel == 0) ? int'(LA) : int'(LB))) mdone[sel] = 1'b1;
    end
  endtask

  task automatic hold(input int sel, input logic v, input int n);
    if (sel == 0) rxd_a = v;
    else          rxd_b = v;
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b, input bit ok, input int gap);
    int w;
    w = (sel == 0) ? int'(WA) : int'(WB);
    model_byte(sel, b, ok);
    hold(sel, 1'b0, w);
    for (int i = 0; i < 8; i++) hold(sel, b[i], w);
    hold(sel, ok, w);
    hold(sel, 1'b1, ok ? gap : gap + 2 * w);
  endtask

  // Write monitors: every strobe must match the next expected write in order
  always @(negedge CLK) begin
    if (rst_a_x === 1'b1 && we_a === 1'b1) begin
      if (expq_a.size() == 0) check("wr_a_unexpected", {32'(addr_a), data_a}, 64'hDEAD);
      else check("wr_a", {32'(addr_a), data_a}, expq_a.pop_front());
      last_we_a = cyc;
    end
    if (done_a === 1'b1 && pd_a === 1'b0) check("done_lat_a", 64'(cyc), 64'(last_we_a + 1));
    if (done_a !== crst_a) check("crst_eq_a", 64'(crst_a), 64'(done_a));
    pd_a = done_a;
  end

  always @(negedge CLK) begin
    if (rst_b_x === 1'b1 && we_b === 1'b1) begin
      if (expq_b.size() == 0) check("wr_b_unexpected", {32'(addr_b), data_b}, 64'hDEAD);
      else check("wr_b", {32'(addr_b), data_b}, expq_b.pop_front());
      last_we_b = cyc;
    end
    if (done_b === 1'b1 && pd_b === 1'b0) check("done_lat_b", 64'(cyc), 64'(last_we_b + 1));
    if (done_b !== crst_b) check("crst_eq_b", 64'(crst_b), 64'(done_b));
    pd_b = done_b;
  end

  task automatic check_reset_a(input string tag);
    check({tag, "_we"},   64'(we_a),   64'd0);
    check({tag, "_addr"}, 64'(addr_a), 64'd0);
    check({tag, "_data"}, 64'(data_a), 64'd0);
    check({tag, "_done"}, 64'(done_a), 64'd0);
    check({tag, "_ferr"}, 64'(ferr_a), 64'd0);
    check({tag, "_crst"}, 64'(crst_a), 64'd0);
  endtask

  initial begin
    logic [7:0] prog[8];
    int         nb;
    prog = '{8'h33, 8'h00, 8'h10, 8'h00, 8'hB3, 8'h81, 8'h20, 8'h40};
    rst_a_x = 1'b0; rxd_a = 1'b1;
    rst_b_x = 1'b0; rxd_b = 1'b1;
    mferr_b = 1'b0;
    model_reset(0);
    model_reset(1);
    repeat (3) @(negedge CLK);
    check_reset_a("rst0");
    check("rst0_crst_b", 64'(crst_b), 64'd0);
    rst_a_x = 1'b1;
    rst_b_x = 1'b1;
    repeat (4) @(negedge CLK);

    // Short low glitch while idle must be rejected silently
    hold(0, 1'b0, 2);
    hold(0, 1'b1, 4 * WA);
    check("glitch_ferr", 64'(ferr_a), 64'd0);
    check("glitch_addr", 64'(addr_a), 64'd0);

    // Framing error drops the byte, following bytes still form word 0
    send_byte(0, 8'h55, 1'b0, WA);
    check("ferr_set", 64'(ferr_a), 64'd1);
    send_byte(0, 8'h11, 1'b1, 2);
    send_byte(0, 8'h22, 1'b1, 0);
    send_byte(0, 8'h33, 1'b1, 1);
    send_byte(0, 8'h44, 1'b1, 3);
    check("ferr_word_pending", 64'(expq_a.size()), 64'd0);
    check("ferr_word_addr", 64'(addr_a), 64'd0);
    check("ferr_word_data", 64'(data_a), 64'h44332211);
    check("ferr_word_done", 64'(done_a), 64'd0);

    // Reset in the middle of word 1 discards everything
    send_byte(0, 8'hAA, 1'b1, 1);
    send_byte(0, 8'hBB, 1'b1, 1);
    rst_a_x = 1'b0;
    model_reset(0);
    #1;
    check_reset_a("rst_mid");
    repeat (3) @(negedge CLK);
    rst_a_x = 1'b1;
    repeat (4) @(negedge CLK);

    // Two-word program load
    for (int i = 0; i < 8; i++) send_byte(0, prog[i], 1'b1, $urandom_range(0, 3));
    repeat (2) @(negedge CLK);
    check("load_pending", 64'(expq_a.size()), 64'd0);
    check("load_done", 64'(done_a), 64'd1);
    check("load_crst", 64'(crst_a), 64'd1);
    check("load_addr", 64'(addr_a), 64'(LA - 1));
    check("load_data", 64'(data_a), 64'h402081B3);
    check("load_ferr", 64'(ferr_a), 64'd0);

    // Bytes after completion are ignored, but framing errors still register
    for (int i = 0; i < 4; i++) send_byte(0, 8'($urandom), 1'b1, 1);
    check("post_addr", 64'(addr_a), 64'(LA - 1));
    check("post_data", 64'(data_a), 64'h402081B3);
    check("post_done", 64'(done_a), 64'd1);
    send_byte(0, 8'h5A, 1'b0, 2);
    check("post_ferr", 64'(ferr_a), 64'd1);

    // Randomized back-to-back traffic on the fast instance
    nb = 0;
    while (!mdone[1] && nb < 400) begin
      bit ok;
      ok = (nb == 5) ? 1'b0 : ($urandom_range(0, 9) != 0);
      if (!ok) mferr_b = 1'b1;
      send_byte(1, 8'($urandom), ok, $urandom_range(0, 2));
      nb++;
    end
    check("rnd_model_done", 64'(mdone[1]), 64'd1);
    for (int i = 0; i < 4; i++) send_byte(1, 8'($urandom), 1'b1, 0);
    hold(1, 1'b1, 4);
    check("rnd_pending", 64'(expq_b.size()), 64'd0);
    check("rnd_done", 64'(done_b), 64'd1);
    check("rnd_crst", 64'(crst_b), 64'd1);
    check("rnd_addr", 64'(addr_b), 64'(LB - 1));
    check("rnd_ferr", 64'(ferr_b), 64'(mferr_b));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter SERIAL_WCNT, default 20, meaning CLK cycles per serial bit (minimum 4).
REQ-002 SHALL have parameter LOAD_WORDS, default 64, meaning the number of 32-bit words to load, range 1..2^ADDR_W.
REQ-003 SHALL have parameter ADDR_W, default 9, meaning the IMEM word-address width.
REQ-004 SHALL have port CLK  in  1  system clock; all logic on posedge.
REQ-005 SHALL have port RST_X  in  1  reset: one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port RXD  in  1  UART serial input, idle high, 8N1, LSB first.
REQ-007 SHALL have port O_WE  out  1  IMEM write strobe, one cycle per word.
REQ-008 SHALL have port O_ADDR  out  ADDR_W  IMEM word address.
REQ-009 SHALL have port O_DATA  out  32  IMEM write data.
REQ-010 SHALL have port O_CORE_RST_X  out  1  active-low core reset; holds the core in reset until the load completes.
REQ-011 SHALL have port O_DONE  out  1  load complete, sticky.
REQ-012 SHALL have port O_FERR  out  1  framing error seen, sticky.

Function
REQ-013 SHALL pass RXD through a 2-flop synchronizer; synchronizer flops reset to 1; all RX decisions use the synchronized value.
REQ-014 SHALL implement RX FSM states IDLE, START, DATA, STOP; reset state IDLE.
REQ-015 IDLE -> START SHALL occur on the first cycle the synchronized RXD is 0.
REQ-016 START SHALL wait SERIAL_WCNT/2 cycles (floor), then resample: 1 -> IDLE (glitch, no error); 0 -> DATA.
REQ-017 DATA SHALL sample 8 bits at SERIAL_WCNT-cycle spacing from the start-bit midpoint, shifting LSB first, with a 3-bit bit counter.
REQ-018 STOP SHALL sample once at SERIAL_WCNT cycles after the last data sample: 1 -> byte valid; 0 -> set O_FERR, discard the byte; both -> IDLE.
REQ-019 SHALL assemble valid bytes little-endian into a word: byte 0 -> [7:0] ... byte 3 -> [31:24]; 2-bit byte counter wraps 3->0.
REQ-020 On the 4th valid byte SHALL assert O_WE for exactly one cycle, the cycle after the stop-bit sample, with O_ADDR = word counter and O_DATA = assembled word.
REQ-021 Word counter (ADDR_W+1 bits) SHALL increment on each O_WE.
REQ-022 O_ADDR and O_DATA SHALL hold their last values when O_WE=0.
REQ-023 When the word counter reaches LOAD_WORDS, O_DONE and O_CORE_RST_X SHALL both go 1 in the same cycle (the cycle after the final O_WE) and stay 1 until reset.
REQ-024 After O_DONE, received bytes SHALL be ignored: no O_WE and no counter change; O_FERR still updates.
REQ-025 A discarded (framing-error) byte SHALL NOT advance the byte counter; the partial word is retained.
REQ-026 O_CORE_RST_X SHALL be registered and glitch-free.

Reset
REQ-027 While RST_X=0, SHALL force O_WE=0, O_ADDR=0, O_DATA=0, O_DONE=0, O_FERR=0, O_CORE_RST_X=0, FSM=IDLE, and all counters 0, asynchronously.
REQ-028 Reset mid-byte or mid-word SHALL discard partial data; the load restarts at address 0 after release.
REQ-029 The first start bit SHALL be recognized no earlier than 3 cycles after RST_X deasserts.

Verification
REQ-030 Scenario: LOAD_WORDS=2, SERIAL_WCNT=8; send bytes 33 00 10 00 B3 81 20 40 -> O_WE pulses twice: addr 0 data 0x00100033, addr 1 data 0x402081B3; O_DONE=O_CORE_RST_X=1 one cycle after the 2nd pulse.
REQ-031 Scenario: 2-cycle low glitch on RXD while idle -> no byte accepted, O_FERR=0, FSM back in IDLE.
REQ-032 Scenario: byte 0x55 with stop bit 0, then bytes 11 22 33 44 -> O_FERR=1; O_WE once with data 0x44332211 at addr 0.
REQ-033 Scenario: after O_DONE, send 4 further bytes -> no O_WE; O_ADDR stays at LOAD_WORDS-1.
REQ-034 Scenario: assert RST_X=0 after 2 bytes of word 1, release, send a full word -> write at addr 0; all outputs 0 during reset.
REQ-035 Scenario: back-to-back bytes with no idle gap between stop and next start at SERIAL_WCNT=4 -> all bytes received, correct words written.
